ahb_lite_mem_slave: RTL and testbench

- Zero-wait-state AHB-Lite slave backed by a byte-addressed memory array.
- Used as the behavioural memory behind the core's fetch, load/store and debug AHB masters.
- Recognises writes to a mailbox address and emits a one-cycle strobe plus the written data, which the bench uses for console output and end-of-test detection.

---
 rtl/ahb_lite_pkg.sv | 34 +++
 rtl/ahb_lite_byte_en.sv | 34 +++
 rtl/ahb_lite_mem_slave.sv | 133 +++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings and defaults for the behavioural memory slave:
//   - htrans_e : transfer type encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - hsize_e  : transfer size encodings (byte .. dword)
//   - MAILBOX_ADDR_DEFAULT / MEM_BYTES_DEFAULT : default slave parameters
//   - clamp_size() : folds sizes wider than the 64-bit bus down to a dword
// ----------------------------------------------------------------------------
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3
   } hsize_e;

   localparam logic [31:0] MAILBOX_ADDR_DEFAULT = 32'hD058_0000;
   localparam int unsigned MEM_BYTES_DEFAULT    = 32'd1 << 20;

   // The data bus is 64 bits wide, so anything larger than a dword is
   // handled as a dword.
   function automatic logic [2:0] clamp_size(input logic [2:0] size);
      return (size > HSIZE_DWORD) ? HSIZE_DWORD : size;
   endfunction

endpackage

// File: rtl/ahb_lite_byte_en.sv
// ----------------------------------------------------------------------------
// ahb_lite_byte_en
// Maps a transfer's low address bits and size to the active byte lanes of
// the 64-bit data bus. Lanes run from addr_i up to addr_i + 2^size - 1;
// lanes past 7 are dropped rather than wrapped into the next dword.
//   addr_i    [2:0] : byte offset within the dword
//   size_i    [2:0] : HSIZE (log2 bytes), values above 3 act as 3
//   byte_en_o [7:0] : one enable per byte lane, bit i = HWDATA[8i+7:8i]
// ----------------------------------------------------------------------------
module ahb_lite_byte_en
   import ahb_lite_pkg::*;
(
   input  logic [2:0] addr_i,
   input  logic [2:0] size_i,
   output logic [7:0] byte_en_o
);

   logic [3:0] num_bytes;
   logic [4:0] lane_first;
   logic [4:0] lane_end;   // one past the last lane; may exceed 8

   // NOTE: every output of a combinational block gets a default before any
   // conditional logic so no path leaves it unassigned and infers a latch.
   always_comb begin
      byte_en_o  = '0;
      num_bytes  = 4'd1 << clamp_size(size_i);
      lane_first = {2'b00, addr_i};
      lane_end   = lane_first + {1'b0, num_bytes};
      for (int i = 0; i < 8; i++) begin
         byte_en_o[i] = (5'(i) >= lane_first) && (5'(i) < lane_end);
      end
   end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// ----------------------------------------------------------------------------
// ahb_lite_mem_slave
// Zero-wait-state AHB-Lite slave backed by a byte-addressed memory (mem),
// hierarchically preloadable, one byte per entry. A write to MAILBOX_ADDR
// additionally pulses mailbox_write for its data-phase cycle so the
// environment can capture console output / end-of-test codes.
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HREADY  : address-phase controls
//   HBURST, HPROT          : accepted but ignored
//   HWDATA                 : write data (data phase)
//   HREADYOUT, HRESP       : always ready / OKAY
//   HRDATA                 : full dword at the data-phase address
//   mailbox_write          : one-cycle strobe on a mailbox write
//   WriteData              : HWDATA pass-through for the mailbox consumer
// ----------------------------------------------------------------------------
module ahb_lite_mem_slave
   import ahb_lite_pkg::*;
#(
   parameter int unsigned MEM_BYTES    = MEM_BYTES_DEFAULT,
   parameter logic [31:0] MAILBOX_ADDR = MAILBOX_ADDR_DEFAULT
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [63:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [63:0] HRDATA,
   output logic        mailbox_write,
   output logic [63:0] WriteData
);

   localparam int unsigned ADDR_W = $clog2(MEM_BYTES);

   logic [7:0] mem [MEM_BYTES];

   logic [31:0] last_haddr_q, last_haddr_d;
   logic [2:0]  last_hsize_q, last_hsize_d;
   logic        write_q,      write_d;
   logic        read_q,       read_d;

   logic              accept;
   logic [7:0]        byte_en;
   logic [ADDR_W-4:0] dword_idx;

   // Only NONSEQ/SEQ carry a transfer; IDLE/BUSY are ignored.
   assign accept = HSEL & HREADY &
                   (htrans_e'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ});

   // ---------------------------------------------------------------------
   // Address-phase capture
   // ---------------------------------------------------------------------
   always_comb begin
      last_haddr_d = last_haddr_q;
      last_hsize_d = last_hsize_q;
      write_d      = accept & HWRITE;
      read_d       = accept & ~HWRITE;
      if (accept) begin
         last_haddr_d = HADDR;
         last_hsize_d = HSIZE;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_haddr_q <= '0;
         last_hsize_q <= '0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
      end else begin
         last_haddr_q <= last_haddr_d;
         last_hsize_q <= last_hsize_d;
         write_q      <= write_d;
         read_q       <= read_d;
      end
   end

   // ---------------------------------------------------------------------
   // Memory array
   // ---------------------------------------------------------------------
   ahb_lite_byte_en u_byte_en (
      .addr_i    (last_haddr_q[2:0]),
      .size_i    (last_hsize_q),
      .byte_en_o (byte_en)
   );

   // Upper address bits above the array size are dropped: accesses wrap.
   assign dword_idx = last_haddr_q[ADDR_W-1:3];

   // NOTE: the array has no reset branch; its contents come from preloading
   // and must survive reset. A reset arriving mid data phase clears write_q
   // asynchronously, which is what stops that write from committing.
   always_ff @(posedge HCLK) begin
      if (write_q) begin
         for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) begin
               mem[{dword_idx, 3'(i)}] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   // Full little-endian dword; the master picks the lanes it asked for.
   always_comb begin
      HRDATA = '0;
      for (int k = 0; k < 8; k++) begin
         HRDATA[8*k +: 8] = mem[{dword_idx, 3'(k)}];
      end
   end

   // ---------------------------------------------------------------------
   // Fixed response and mailbox
   // ---------------------------------------------------------------------
   assign HREADYOUT     = 1'b1;
   assign HRESP         = 1'b0;
   assign WriteData     = HWDATA;
   assign mailbox_write = write_q & (last_haddr_q == MAILBOX_ADDR) & HRESETn;

   // Bus signals this memory has no use for.
   logic unused_ok;
   assign unused_ok = ^{HBURST, HPROT, read_q};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_mem_slave
// Directed and randomized bus traffic against ahb_lite_mem_slave, checked
// against a byte-array model of memory plus a record of the transfer that
// is currently in its data phase.
// ----------------------------------------------------------------------------
module tb_ahb_lite_mem_slave;
   import ahb_lite_pkg::*;

   localparam int unsigned MEM_BYTES = 32'd1 << 20;
   localparam logic [31:0] MB        = 32'hD058_0000;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [63:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [63:0] HRDATA;
   logic        mailbox_write;
   logic [63:0] WriteData;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   ahb_lite_mem_slave #(
      .MEM_BYTES    (MEM_BYTES),
      .MAILBOX_ADDR (MB)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HSEL          (HSEL),
      .HADDR         (HADDR),
      .HTRANS        (HTRANS),
      .HWRITE        (HWRITE),
      .HSIZE         (HSIZE),
      .HBURST        (HBURST),
      .HPROT         (HPROT),
      .HWDATA        (HWDATA),
      .HREADY        (HREADY),
      .HREADYOUT     (HREADYOUT),
      .HRESP         (HRESP),
      .HRDATA        (HRDATA),
      .mailbox_write (mailbox_write),
      .WriteData     (WriteData)
   );

   // Reference model: memory bytes plus the transfer now in its data phase.
   logic [7:0]  ref_mem [MEM_BYTES];
   bit          dp_write;
   logic [31:0] dp_addr;
   logic [2:0]  dp_size;

   int checks   = 0;
   int failures = 0;

   logic [63:0] obs_rdata;
   logic [63:0] obs_wdata;
   logic        obs_mb;

   function automatic int unsigned ref_base(input logic [31:0] a);
      int unsigned wrapped;
      wrapped = a % MEM_BYTES;
      return wrapped - (wrapped % 8);
   endfunction

   function automatic logic [63:0] ref_dword(input logic [31:0] a);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = ref_mem[ref_base(a) + k];
      return d;
   endfunction

   task automatic ref_commit(input logic [31:0] a, input logic [2:0] size,
                             input logic [63:0] wd);
      int n;
      int off;
      n   = 1 << ((size > 3) ? 3 : int'(size));
      off = a % 8;
      for (int i = off; i < off + n && i < 8; i++) begin
         ref_mem[ref_base(a) + i] = wd[8*i +: 8];
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic sel, input logic ready, input logic [1:0] trans,
                        input logic write, input logic [31:0] addr,
                        input logic [2:0] size, input logic [63:0] wd);
      HSEL   = sel;
      HREADY = ready;
      HTRANS = trans;
      HWRITE = write;
      HADDR  = addr;
      HSIZE  = size;
      HWDATA = wd;
      HBURST = 3'($urandom);
      HPROT  = 4'($urandom);
   endtask

   // One bus cycle, entered just after a rising edge: drive the address
   // phase of the next transfer and the data of the current one, check the
   // current data phase mid-cycle, then advance the model at the edge.
   task automatic step(input logic sel, input logic ready, input logic [1:0] trans,
                       input logic write, input logic [31:0] addr,
                       input logic [2:0] size, input logic [63:0] wd);
      drive(sel, ready, trans, write, addr, size, wd);
      @(negedge HCLK);
      obs_rdata = HRDATA;
      obs_wdata = WriteData;
      obs_mb    = mailbox_write;
      check("rdata", HRDATA, ref_dword(dp_addr));
      check("mailbox", 64'(mailbox_write), 64'(dp_write && dp_addr == MB));
      check("writedata", WriteData, HWDATA);
      check("ready_resp", 64'({HREADYOUT, HRESP}), 64'(2'b10));
      @(posedge HCLK);
      if (dp_write) ref_commit(dp_addr, dp_size, HWDATA);
      if (sel && ready && trans[1]) begin
         dp_write = write;
         dp_addr  = addr;
         dp_size  = size;
      end else begin
         dp_write = 1'b0;
      end
      #1;
   endtask

   task automatic idle(input logic [63:0] wd);
      step(1'b1, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 3'd0, wd);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [63:0] old;
      logic [63:0] wd;
      logic [31:0] a;

      HRESETn = 1'b0;
      drive(1'b0, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 3'd0, 64'h0);
      dp_write = 1'b0;
      dp_addr  = '0;
      dp_size  = '0;

      // Preload the windows the test touches, in DUT and model alike.
      for (int unsigned i = 0; i < 32'h400; i++) begin
         a[7:0] = 8'($urandom);
         dut.mem[i] = a[7:0];
         ref_mem[i] = a[7:0];
      end
      for (int unsigned i = 32'h8_0000; i < 32'h8_0010; i++) begin
         a[7:0] = 8'($urandom);
         dut.mem[i] = a[7:0];
         ref_mem[i] = a[7:0];
      end
      for (int unsigned i = 0; i < 8; i++) begin
         dut.mem[32'h80 + i] = 8'(i + 1);
         ref_mem[32'h80 + i] = 8'(i + 1);
      end

      // Reset state.
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_readyout", 64'(HREADYOUT), 64'd1);
      check("rst_resp", 64'(HRESP), 64'd0);
      check("rst_mailbox", 64'(mailbox_write), 64'd0);
      check("rst_rdata", HRDATA, ref_dword(32'h0));
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      // Reset during a mailbox write data phase: no commit, strobe drops.
      old = ref_dword(MB);
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, MB, HSIZE_DWORD, rnd64());
      drive(1'b1, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 3'd0, ~old);
      #2;
      check("mb_before_reset", 64'(mailbox_write), 64'd1);
      HRESETn = 1'b0;
      #1;
      check("mb_in_reset", 64'(mailbox_write), 64'd0);
      check("ready_in_reset", 64'({HREADYOUT, HRESP}), 64'(2'b10));
      check("rdata_in_reset", HRDATA, ref_dword(32'h0));
      @(posedge HCLK);
      #1;
      HRESETn  = 1'b1;
      dp_write = 1'b0;
      dp_addr  = '0;
      dp_size  = '0;
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, MB, HSIZE_DWORD, rnd64());
      idle(rnd64());
      check("reset_no_commit", obs_rdata, old);

      // Preloaded read.
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h84, HSIZE_WORD, rnd64());
      idle(rnd64());
      check("preload_read", obs_rdata, 64'h0807060504030201);

      // Single byte-lane write, then dword read of the same dword.
      old = ref_dword(32'h100);
      wd  = 64'hAABBCCDD_EEFF1122;
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h103, HSIZE_BYTE, rnd64());
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_DWORD, wd);
      idle(rnd64());
      check("byte_lane", obs_rdata, {old[63:32], wd[31:24], old[23:0]});

      // Dword at offset 6 keeps only lanes 6 and 7.
      old = ref_dword(32'h108);
      wd  = rnd64();
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h10E, HSIZE_DWORD, rnd64());
      step(1'b1, 1'b1, HTRANS_SEQ, 1'b0, 32'h108, HSIZE_DWORD, wd);
      idle(rnd64());
      check("lane_clip", obs_rdata, {wd[63:48], old[47:0]});

      // Back-to-back word write then read, no wait state.
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h200, HSIZE_WORD, rnd64());
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h200, HSIZE_WORD,
           {32'h1234_5678, 32'hDEAD_BEEF});
      idle(rnd64());
      check("b2b_read", obs_rdata[31:0], 64'hDEAD_BEEF);

      // Mailbox: two pulses, then a neighbouring address with none.
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, MB, HSIZE_BYTE, rnd64());
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, MB, HSIZE_BYTE, 64'h41);
      check("mb_pulse1", 64'(obs_mb), 64'd1);
      check("mb_data1", obs_wdata[7:0], 64'h41);
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, MB + 32'h8, HSIZE_BYTE, 64'hFF);
      check("mb_pulse2", 64'(obs_mb), 64'd1);
      check("mb_data2", obs_wdata[7:0], 64'hFF);
      idle(64'h5A);
      check("mb_other_addr", 64'(obs_mb), 64'd0);
      idle(rnd64());
      check("mb_gap", 64'(obs_mb), 64'd0);

      // Gating: HREADY low, HSEL low, IDLE and BUSY never write.
      old = ref_dword(32'h300);
      step(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, 32'h300, HSIZE_DWORD, rnd64());
      step(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h300, HSIZE_DWORD, rnd64());
      check("gate_ready", 64'(obs_mb), 64'd0);
      step(1'b1, 1'b1, HTRANS_IDLE, 1'b1, 32'h300, HSIZE_DWORD, rnd64());
      step(1'b1, 1'b1, HTRANS_BUSY, 1'b1, 32'h300, HSIZE_DWORD, rnd64());
      step(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, MB, HSIZE_DWORD, rnd64());
      step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h300, HSIZE_DWORD, rnd64());
      check("gate_mb", 64'(obs_mb), 64'd0);
      idle(rnd64());
      check("gate_mem", obs_rdata, old);

      // Randomized pipelined traffic.
      for (int n = 0; n < 400; n++) begin
         a = ($urandom_range(0, 15) == 0) ? MB : 32'($urandom_range(0, 32'h3FF));
         step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
              2'($urandom), 1'($urandom), a, 3'($urandom), rnd64());
      end
      idle(rnd64());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
